// File: rtl/cbd_bit_sequencer.sv
// cbd_bit_sequencer: unpacks a byte stream LSB-first into 2*ETA-bit CBD groups with index and last flag
module cbd_bit_sequencer #(
   parameter int ETA       = 2,
   parameter int MAX_BYTES = 256,
   parameter int GROUP_W   = 2 * ETA
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [$clog2(MAX_BYTES):0]     len,
   output logic                           busy,
   output logic                           done,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [7:0]                     in_byte,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [GROUP_W-1:0]             out_bits,
   output logic [$clog2(MAX_BYTES*8)-1:0] out_idx,
   output logic                           out_last
);
   localparam int BUF_W = GROUP_W + 8;
   localparam int CNT_W = $clog2(BUF_W + 1);
   localparam int LEN_W = $clog2(MAX_BYTES) + 1;
   localparam int IDX_W = $clog2(MAX_BYTES * 8);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam logic [CNT_W-1:0] GW    = CNT_W'(GROUP_W);
   localparam logic [CNT_W-1:0] GW2   = CNT_W'(2 * GROUP_W);
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BYTES);

   logic [0:0]       state_q;
   logic [BUF_W-1:0] buf_q, buf_p, buf_d;
   logic [CNT_W-1:0] cnt_q, cnt_p, cnt_d;
   logic [LEN_W-1:0] left_q, left_d;
   logic [IDX_W-1:0] gidx_q, gidx_d;
   logic             done_q;
   logic             run, push, pop, leave;

   assign run       = state_q == S_RUN;
   assign busy      = run;
   assign done      = done_q;
   // in_ready looks only at registered state so out_ready never reaches it combinationally
   assign in_ready  = run && left_q != '0 && cnt_q <= GW;
   assign out_valid = run && cnt_q >= GW;
   assign out_bits  = buf_q[GROUP_W-1:0];
   assign out_idx   = gidx_q;
   assign out_last  = out_valid && left_q == '0 && cnt_q < GW2;
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && in_ready;

   always_comb begin
      cnt_p  = pop ? cnt_q - GW : cnt_q;
      buf_p  = pop ? buf_q >> GROUP_W : buf_q;
      buf_d  = push ? buf_p | (BUF_W'(in_byte) << cnt_p) : buf_p;
      cnt_d  = push ? cnt_p + CNT_W'(8) : cnt_p;
      left_d = push ? left_q - LEN_W'(1) : left_q;
      gidx_d = pop ? gidx_q + IDX_W'(1) : gidx_q;
      leave  = left_d == '0 && cnt_d < GW;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
         cnt_q   <= '0;
         left_q  <= '0;
         gidx_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= run && leave;
         if (!run) begin
            if (start) begin
               state_q <= S_RUN;
               left_q  <= len > MAX_L ? MAX_L : len;
               cnt_q   <= '0;
               gidx_q  <= '0;
               buf_q   <= '0;
            end
         end else if (leave) begin
            // leftover bits short of a full group are dropped here
            state_q <= S_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            left_q  <= '0;
            gidx_q  <= gidx_d;
         end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            left_q <= left_d;
            gidx_q <= gidx_d;
         end
      end
   end
endmodule

// File: tb/tb_cbd_bit_sequencer.sv
// tb_cbd_bit_sequencer: scoreboard bench driving an ETA=2 and an ETA=3 instance with directed jobs
module tb_cbd_bit_sequencer;
   typedef struct {
      logic [5:0] bits;
      int         idx;
      bit         last;
   } grp_t;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [8:0] len = '0;
   logic [7:0] in_byte = '0;
   int sel = 2;

   logic b2, d2, ir2, ov2, ol2, b3, d3, ir3, ov3, ol3;
   logic [3:0] ob2;
   logic [5:0] ob3;
   logic [10:0] oi2, oi3;
   logic busy, done, in_ready, out_valid, out_last;
   logic [5:0] out_bits;
   logic [10:0] out_idx;

   int total = 0, bad = 0;
   grp_t exp_q[$];
   logic [5:0] got[$];
   logic [7:0] src[$];
   bit bits_m[$];
   bit busy_m = 0, done_m = 0;
   int bl_m = 0, cnt_m = 0, gen_idx = 0, total_m = 0, stall = 0;

   always #5 clk = ~clk;

   assign busy      = sel == 2 ? b2 : b3;
   assign done      = sel == 2 ? d2 : d3;
   assign in_ready  = sel == 2 ? ir2 : ir3;
   assign out_valid = sel == 2 ? ov2 : ov3;
   assign out_last  = sel == 2 ? ol2 : ol3;
   assign out_bits  = sel == 2 ? {2'b00, ob2} : ob3;
   assign out_idx   = sel == 2 ? oi2 : oi3;

   cbd_bit_sequencer #(.ETA(2)) u2 (
      .clk(clk), .rst(rst), .start(start && sel == 2), .len(len), .busy(b2), .done(d2),
      .in_valid(in_valid && sel == 2), .in_ready(ir2), .in_byte(in_byte),
      .out_valid(ov2), .out_ready(out_ready && sel == 2), .out_bits(ob2), .out_idx(oi2), .out_last(ol2)
   );

   cbd_bit_sequencer #(.ETA(3)) u3 (
      .clk(clk), .rst(rst), .start(start && sel == 3), .len(len), .busy(b3), .done(d3),
      .in_valid(in_valid && sel == 3), .in_ready(ir3), .in_byte(in_byte),
      .out_valid(ov3), .out_ready(out_ready && sel == 3), .out_bits(ob3), .out_idx(oi3), .out_last(ol3)
   );

   function automatic int gw();
      return sel == 2 ? 4 : 6;
   endfunction

   function automatic logic [31:0] gat(input int i);
      return i < got.size() ? 32'(got[i]) : 32'hffff_ffff;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: drive at negedge, compare against the model, then advance the model past the posedge
   task automatic step(input bit st, input int ln);
      logic [7:0] b;
      logic [5:0] g;
      bit iv_e, ov_e, inf, outf;
      @(negedge clk);
      start = st;
      len = 9'(ln);
      in_valid = src.size() > 0 && $urandom_range(99) >= stall;
      in_byte = 8'h00;
      if (src.size() > 0) in_byte = src[0];
      out_ready = $urandom_range(99) >= stall;
      #1;
      iv_e = busy_m && bl_m != 0 && cnt_m <= gw();
      ov_e = busy_m && cnt_m >= gw();
      chk("busy", {31'b0, busy}, {31'b0, busy_m});
      chk("done", {31'b0, done}, {31'b0, done_m});
      chk("in_ready", {31'b0, in_ready}, {31'b0, iv_e});
      chk("out_valid", {31'b0, out_valid}, {31'b0, ov_e});
      if (ov_e && exp_q.size() > 0) begin
         chk("out_bits", {26'b0, out_bits}, {26'b0, exp_q[0].bits});
         chk("out_idx", {21'b0, out_idx}, exp_q[0].idx);
         chk("out_last", {31'b0, out_last}, {31'b0, exp_q[0].last});
      end else chk("out_last_idle", {31'b0, out_last}, 0);
      inf = in_valid && iv_e;
      outf = ov_e && out_ready;
      if (outf) begin
         got.push_back(exp_q[0].bits);
         void'(exp_q.pop_front());
         cnt_m -= gw();
      end
      if (inf) begin
         b = src.pop_front();
         for (int j = 0; j < 8; j++) bits_m.push_back(b[j]);
         cnt_m += 8;
         bl_m--;
         while (bits_m.size() >= gw()) begin
            g = '0;
            for (int j = 0; j < gw(); j++) g[j] = bits_m.pop_front();
            exp_q.push_back('{g, gen_idx, gen_idx == total_m - 1});
            gen_idx++;
         end
      end
      if (busy_m && bl_m == 0 && cnt_m < gw()) begin
         busy_m = 0;
         done_m = 1;
         cnt_m = 0;
         bits_m.delete();
      end else begin
         done_m = 0;
         if (!busy_m && st) begin
            busy_m = 1;
            bl_m = ln > 256 ? 256 : ln;
            cnt_m = 0;
            gen_idx = 0;
            total_m = bl_m * 8 / gw();
            bits_m.delete();
            exp_q.delete();
         end
      end
   endtask

   task automatic drain(input bit busy_start, input int chain_len);
      int c = 0;
      while (busy_m && c < 3000) begin
         step(busy_start && c == 2, 9);
         c++;
      end
      chk("job_timeout", {31'b0, busy_m}, 0);
      step(chain_len >= 0, chain_len >= 0 ? chain_len : 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_busy", {30'b0, b2, b3}, 0);
      chk("rst_done", {30'b0, d2, d3}, 0);
      chk("rst_in_ready", {30'b0, ir2, ir3}, 0);
      chk("rst_out_valid", {30'b0, ov2, ov3}, 0);
      chk("rst_out_last", {30'b0, ol2, ol3}, 0);
      chk("rst_out_bits", {22'b0, ob2, ob3}, 0);
      chk("rst_out_idx", {10'b0, oi2, oi3}, 0);
      rst = 1'b0;
      busy_m = 0;
      done_m = 0;
      bl_m = 0;
      cnt_m = 0;
      exp_q.delete();
      bits_m.delete();
      src.delete();
   endtask

   initial begin
      do_reset();

      sel = 2; stall = 0; got.delete();
      src.push_back(8'hA5);
      step(1, 1);
      drain(0, -1);
      chk("a5_count", got.size(), 2);
      chk("a5_g0", gat(0), 32'h5);
      chk("a5_g1", gat(1), 32'hA);

      sel = 3; got.delete();
      src.push_back(8'h01); src.push_back(8'h02); src.push_back(8'h03);
      step(1, 3);
      drain(0, -1);
      chk("e3_count", got.size(), 4);
      chk("e3_g0", gat(0), 32'h01);
      chk("e3_g1", gat(1), 32'h08);
      chk("e3_g2", gat(2), 32'h30);
      chk("e3_g3", gat(3), 32'h00);

      sel = 2; stall = 30; got.delete();
      for (int i = 0; i < 128; i++) src.push_back(8'($urandom));
      step(1, 128);
      drain(0, -1);
      chk("rand128_count", got.size(), 256);

      sel = 3; stall = 0; got.delete();
      src.push_back(8'hFF);
      step(1, 1);
      drain(0, -1);
      chk("ff_count", got.size(), 1);
      chk("ff_g0", gat(0), 32'h3F);

      sel = 2; got.delete();
      step(1, 0);
      drain(0, -1);
      chk("len0_count", got.size(), 0);

      sel = 2; stall = 0; got.delete();
      for (int i = 0; i < 300; i++) src.push_back(8'($urandom));
      step(1, 300);
      drain(0, -1);
      chk("clamp_count", got.size(), 512);
      chk("clamp_left", src.size(), 44);
      src.delete();

      sel = 2; stall = 0;
      for (int i = 0; i < 20; i++) src.push_back(8'($urandom));
      step(1, 20);
      for (int c = 0; c < 200 && src.size() > 15; c++) step(0, 0);
      chk("abort_fed", src.size(), 15);
      do_reset();
      step(0, 0);
      got.delete();
      src.push_back(8'h3C); src.push_back(8'h96);
      step(1, 2);
      drain(0, -1);
      chk("post_abort_count", got.size(), 4);
      chk("post_abort_g0", gat(0), 32'hC);
      chk("post_abort_g3", gat(3), 32'h9);

      sel = 3; stall = 20; got.delete();
      for (int i = 0; i < 6; i++) src.push_back(8'($urandom));
      step(1, 4);
      drain(1, 2);
      drain(0, -1);
      chk("b2b_count", got.size(), 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
